// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction-fetch control FSM for a 5-stage pipeline.
// Sequences the post-reset boot delay, stalls the front end on memory waits
// and load-use hazards, and redirects the PC on taken branches. A branch that
// resolves while the memory is not ready is parked in a pending register and
// replayed from the REDIRECT state once the memory accepts it.
// Optional build macro: FETCH_CTRL_PERF_CNT_EN enables the saturating
// stall-cycle counter on STALL_CNT; without it STALL_CNT is tied to zero.
module fetch_ctrl #(
    parameter int unsigned BOOT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IMEM_RDY,
    input  logic        LOAD_USE,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TGT,
    output logic        PC_EN,
    output logic        PC_Src,
    output logic [31:0] PC_BRANCH,
    output logic        IFID_EN,
    output logic        IFID_FLUSH,
    output logic        IDEX_FLUSH,
    output logic [1:0]  FSM_STATE,
    output logic [15:0] STALL_CNT
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEMWAIT  = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_boot_cnt;
    logic [31:0] r_pending;
    logic        w_fetching;      // RUN, or MEMWAIT behaving as RUN/waiting
    logic        w_park_branch;   // taken branch that must wait for memory

    assign w_fetching    = (r_state == RUN) || (r_state == MEMWAIT);
    assign w_park_branch = w_fetching && BRANCH_TAKEN && !IMEM_RDY;

    // State register.
    // NOTE: every clocked process uses non-blocking assignments so all flops
    // sample the pre-edge values regardless of process evaluation order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; MEMWAIT with a ready memory follows the RUN rules.
    // NOTE: the default assignment at the top keeps this block latch-free even
    // when a branch of the case does not assign the next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BOOT: begin
                if (r_boot_cnt == BOOT_LAST) begin
                    w_state_nxt = RUN;
                end
            end
            RUN, MEMWAIT: begin
                if (BRANCH_TAKEN && IMEM_RDY) begin
                    w_state_nxt = RUN;
                end else if (BRANCH_TAKEN) begin
                    w_state_nxt = REDIRECT;
                end else if (!IMEM_RDY) begin
                    w_state_nxt = MEMWAIT;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            REDIRECT: begin
                if (IMEM_RDY) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = BOOT;
        endcase
    end

    // Mealy outputs from current state and this cycle's inputs.
    always_comb begin
        PC_EN      = 1'b0;
        PC_Src     = 1'b0;
        IFID_EN    = 1'b0;
        IFID_FLUSH = 1'b1;
        IDEX_FLUSH = 1'b1;
        PC_BRANCH  = BRANCH_TGT;
        case (r_state)
            RUN, MEMWAIT: begin
                if (BRANCH_TAKEN && IMEM_RDY) begin
                    // Redirect immediately and squash the wrong-path fetch.
                    PC_EN   = 1'b1;
                    PC_Src  = 1'b1;
                    IFID_EN = 1'b1;
                end else if (BRANCH_TAKEN) begin
                    // Freeze and flush; the target is replayed from REDIRECT.
                    PC_EN   = 1'b0;
                    IFID_EN = 1'b0;
                end else if (!IMEM_RDY || LOAD_USE) begin
                    // Hold fetch and decode, insert a bubble into EX.
                    IFID_FLUSH = 1'b0;
                end else begin
                    PC_EN      = 1'b1;
                    IFID_EN    = 1'b1;
                    IFID_FLUSH = 1'b0;
                    IDEX_FLUSH = 1'b0;
                end
            end
            REDIRECT: begin
                PC_Src    = 1'b1;
                PC_EN     = IMEM_RDY;
                PC_BRANCH = r_pending;
            end
            default: begin
                // BOOT: everything frozen and flushed.
            end
        endcase
    end

    assign FSM_STATE = r_state;

    // Boot delay counter; only advances while in BOOT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_boot_cnt <= '0;
        end else if (r_state == BOOT) begin
            r_boot_cnt <= r_boot_cnt + 4'd1;
        end
    end

    // Pending branch target, captured only when a taken branch must wait.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pending <= '0;
        end else if (w_park_branch) begin
            r_pending <= BRANCH_TGT;
        end
    end

`ifdef FETCH_CTRL_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic        w_stall_event;

    assign w_stall_event = w_fetching && !PC_EN;

    // Saturating count of fetch stall cycles in RUN/MEMWAIT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (w_stall_event && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign STALL_CNT = r_stall_cnt;
`else
    assign STALL_CNT = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl (BOOT_CYCLES = 2).
// Control outputs are compared as a packed vector:
//   {PC_EN, PC_Src, IFID_EN, IFID_FLUSH, IDEX_FLUSH, FSM_STATE[1:0]}
// STALL_CNT expectations follow FETCH_CTRL_PERF_CNT_EN.
module tb_fetch_ctrl;

`ifdef FETCH_CTRL_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        CLK;
    logic        RST;
    logic        IMEM_RDY;
    logic        LOAD_USE;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TGT;
    logic        PC_EN;
    logic        PC_Src;
    logic [31:0] PC_BRANCH;
    logic        IFID_EN;
    logic        IFID_FLUSH;
    logic        IDEX_FLUSH;
    logic [1:0]  FSM_STATE;
    logic [15:0] STALL_CNT;

    int n_checks = 0;
    int n_errors = 0;

    fetch_ctrl #(.BOOT_CYCLES(2)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .IMEM_RDY     (IMEM_RDY),
        .LOAD_USE     (LOAD_USE),
        .BRANCH_TAKEN (BRANCH_TAKEN),
        .BRANCH_TGT   (BRANCH_TGT),
        .PC_EN        (PC_EN),
        .PC_Src       (PC_Src),
        .PC_BRANCH    (PC_BRANCH),
        .IFID_EN      (IFID_EN),
        .IFID_FLUSH   (IFID_FLUSH),
        .IDEX_FLUSH   (IDEX_FLUSH),
        .FSM_STATE    (FSM_STATE),
        .STALL_CNT    (STALL_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected control vectors.
    localparam logic [6:0] O_BOOT     = 7'b0001100;
    localparam logic [6:0] O_RUN      = 7'b1010001;
    localparam logic [6:0] O_RUN_BR   = 7'b1111101;
    localparam logic [6:0] O_RUN_PARK = 7'b0001101;
    localparam logic [6:0] O_RUN_STL  = 7'b0000101;
    localparam logic [6:0] O_MW_STL   = 7'b0000110;
    localparam logic [6:0] O_MW_PARK  = 7'b0001110;
    localparam logic [6:0] O_MW_RUN   = 7'b1010010;
    localparam logic [6:0] O_RD_WAIT  = 7'b0101111;
    localparam logic [6:0] O_RD_GO    = 7'b1101111;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {25'd0, PC_EN, PC_Src, IFID_EN, IFID_FLUSH, IDEX_FLUSH, FSM_STATE};
    endfunction

    function automatic logic [31:0] stall_exp(input int n);
        return (PERF != 0) ? 32'(n) : 32'd0;
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset with hazards present: must all be masked.
        RST = 1'b1; IMEM_RDY = 1'b1; LOAD_USE = 1'b1;
        BRANCH_TAKEN = 1'b1; BRANCH_TGT = 32'h1234;
        #3;
        check("reset_outs", outs(), {25'd0, O_BOOT});
        check("reset_stall", 32'(STALL_CNT), 32'd0);
        check("reset_pc_branch", PC_BRANCH, 32'h1234);

        // Boot sequence: two frozen cycles, then RUN.
        @(posedge CLK); #1;
        RST = 1'b0;
        #1 check("boot_c1", outs(), {25'd0, O_BOOT});
        tick(); #1 check("boot_c2", outs(), {25'd0, O_BOOT});
        tick(); BRANCH_TAKEN = 1'b0; LOAD_USE = 1'b0;
        #1 check("boot_run_c3", outs(), {25'd0, O_RUN});

        // Taken branch with ready memory: same-cycle redirect.
        BRANCH_TAKEN = 1'b1; BRANCH_TGT = 32'h40;
        #1 check("br_rdy_outs", outs(), {25'd0, O_RUN_BR});
        check("br_rdy_tgt", PC_BRANCH, 32'h40);

        tick(); BRANCH_TAKEN = 1'b0;
        #1 check("br_rdy_stay_run", outs(), {25'd0, O_RUN});

        // Taken branch with memory not ready: park and redirect later.
        BRANCH_TAKEN = 1'b1; BRANCH_TGT = 32'h80; IMEM_RDY = 1'b0;
        #1 check("park_outs", outs(), {25'd0, O_RUN_PARK});
        check("park_tgt", PC_BRANCH, 32'h80);
        tick(); BRANCH_TAKEN = 1'b0; BRANCH_TGT = 32'h10;
        #1 check("redir_w1", outs(), {25'd0, O_RD_WAIT});
        check("redir_w1_tgt", PC_BRANCH, 32'h80);
        tick(); #1 check("redir_w2", outs(), {25'd0, O_RD_WAIT});
        // A new branch during REDIRECT must not replace the pending target.
        tick(); BRANCH_TAKEN = 1'b1; LOAD_USE = 1'b1;
        #1 check("redir_w3", outs(), {25'd0, O_RD_WAIT});
        check("redir_w3_tgt", PC_BRANCH, 32'h80);
        tick(); BRANCH_TAKEN = 1'b0; LOAD_USE = 1'b0; IMEM_RDY = 1'b1;
        #1 check("redir_go", outs(), {25'd0, O_RD_GO});
        check("redir_go_tgt", PC_BRANCH, 32'h80);
        tick(); #1 check("redir_back_run", outs(), {25'd0, O_RUN});
        check("run_tgt_passthru", PC_BRANCH, 32'h10);
        check("stall_after_park", 32'(STALL_CNT), stall_exp(1));

        // Load-use held two cycles.
        LOAD_USE = 1'b1;
        #1 check("lu_c1", outs(), {25'd0, O_RUN_STL});
        tick(); #1 check("lu_c2", outs(), {25'd0, O_RUN_STL});
        tick(); LOAD_USE = 1'b0;
        #1 check("lu_release", outs(), {25'd0, O_RUN});
        check("stall_after_lu", 32'(STALL_CNT), stall_exp(3));

        // Memory wait: RUN -> MEMWAIT -> (ready) behaves like RUN.
        IMEM_RDY = 1'b0;
        #1 check("mw_enter", outs(), {25'd0, O_RUN_STL});
        tick(); #1 check("mw_hold", outs(), {25'd0, O_MW_STL});
        tick(); LOAD_USE = 1'b1;
        #1 check("mw_hold_lu", outs(), {25'd0, O_MW_STL});
        tick(); LOAD_USE = 1'b0; IMEM_RDY = 1'b1;
        #1 check("mw_ready", outs(), {25'd0, O_MW_RUN});
        tick(); #1 check("mw_to_run", outs(), {25'd0, O_RUN});
        check("stall_after_mw", 32'(STALL_CNT), stall_exp(6));

        // Branch while waiting in MEMWAIT parks the target.
        IMEM_RDY = 1'b0;
        tick(); BRANCH_TAKEN = 1'b1; BRANCH_TGT = 32'h44;
        #1 check("mw_park", outs(), {25'd0, O_MW_PARK});
        tick(); BRANCH_TAKEN = 1'b0; BRANCH_TGT = 32'h0; IMEM_RDY = 1'b1;
        #1 check("mw_redir_go", outs(), {25'd0, O_RD_GO});
        check("mw_redir_tgt", PC_BRANCH, 32'h44);
        check("stall_mw_park", 32'(STALL_CNT), stall_exp(8));
        tick(); #1 check("mw_redir_run", outs(), {25'd0, O_RUN});

        // All hazards at once with memory not ready: branch wins.
        IMEM_RDY = 1'b0; LOAD_USE = 1'b1; BRANCH_TAKEN = 1'b1; BRANCH_TGT = 32'hC0;
        #1 check("prio_outs", outs(), {25'd0, O_RUN_PARK});
        tick(); BRANCH_TAKEN = 1'b0; LOAD_USE = 1'b0; BRANCH_TGT = 32'h5;
        #1 check("prio_redir", outs(), {25'd0, O_RD_WAIT});
        check("prio_redir_tgt", PC_BRANCH, 32'hC0);
        check("stall_prio", 32'(STALL_CNT), stall_exp(9));

        // Asynchronous reset mid-REDIRECT discards the pending branch.
        RST = 1'b1;
        #1 check("async_rst_outs", outs(), {25'd0, O_BOOT});
        check("async_rst_stall", 32'(STALL_CNT), 32'd0);
        check("async_rst_tgt", PC_BRANCH, 32'h5);
        tick(); RST = 1'b0; IMEM_RDY = 1'b1;
        #1 check("reboot_c1", outs(), {25'd0, O_BOOT});
        tick(); #1 check("reboot_c2", outs(), {25'd0, O_BOOT});
        tick(); #1 check("reboot_run", outs(), {25'd0, O_RUN});
        check("reboot_no_redir", PC_BRANCH, 32'h5);

        // Long memory stall: counter saturates (or stays zero when disabled).
        IMEM_RDY = 1'b0;
        if (PERF != 0) begin
            repeat (65540) tick();
            #1 check("stall_sat", 32'(STALL_CNT), 32'hFFFF);
            repeat (5) tick();
            #1 check("stall_sat_hold", 32'(STALL_CNT), 32'hFFFF);
        end else begin
            repeat (40) tick();
            #1 check("stall_tied_zero", 32'(STALL_CNT), 32'd0);
        end
        check("long_wait_state", outs(), {25'd0, O_MW_STL});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
